// File: rtl/pes_ram_burst_master.sv
// Burst initiator for one port of pes_ram_design: streams write beats into the RAM, or read
// beats out through a 2-entry skid FIFO. Define PES_RAM_BURST_CHK_EN to add the chk_sum output.
module pes_ram_burst_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done
`ifdef PES_RAM_BURST_CHK_EN
    ,
    output logic [DATA_W-1:0] chk_sum
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, DONE = 2'd3} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [LEN_W-1:0]  remaining;
    logic              in_flight;
    logic [1:0]        fifo_count;
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [DATA_W-1:0] fifo_mem [2];

    logic              wr_fire;
    logic              rd_pop;
    logic              issue;
    logic              last_pop;
    logic [2:0]        credits;

    assign wr_fire  = wr_ready & wr_valid;
    assign rd_valid = (fifo_count != 2'd0);
    assign rd_data  = fifo_mem[fifo_rd_ptr];
    assign rd_pop   = rd_valid & rd_ready;

    // A same-cycle pop frees its slot, which keeps one beat per cycle with rd_ready high.
    assign credits  = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, rd_pop};
    assign issue    = (state == RD) && (remaining != '0) && (credits < 3'd2);
    assign last_pop = (remaining == '0) && !in_flight && (fifo_count == 2'd1) && rd_pop;

    // wr_ready is cleared by the asynchronous reset, so ram_we falls with rst_n.
    assign ram_we   = wr_fire;
    assign ram_addr = (state == WR || state == RD) ? cur_addr : last_addr;
    assign ram_data = wr_ready ? wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_ready    <= 1'b0;
            cur_addr    <= '0;
            last_addr   <= '0;
            remaining   <= '0;
            in_flight   <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
        end else begin
            in_flight  <= issue;
            fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, rd_pop};
            if (in_flight) begin
                fifo_wr_ptr <= ~fifo_wr_ptr;
            end
            if (rd_pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            if (issue) begin
                last_addr <= cur_addr;
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_len;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (cmd_write) begin
                            state    <= WR;
                            wr_ready <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                WR: begin
                    if (wr_fire) begin
                        last_addr <= cur_addr;
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state    <= DONE;
                            wr_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (last_pop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data returns one cycle after issue; the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (in_flight) begin
            fifo_mem[fifo_wr_ptr] <= ram_q;
        end
    end

`ifdef PES_RAM_BURST_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_sum <= '0;
        end else if (state == IDLE && cmd_valid) begin
            chk_sum <= '0;
        end else if (wr_fire) begin
            chk_sum <= chk_sum ^ wr_data;
        end else if (rd_pop) begin
            chk_sum <= chk_sum ^ rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_pes_ram_burst_master.sv
// Randomized bench for pes_ram_burst_master against a behavioural RAM and a shadow-memory model.
module tb_pes_ram_burst_master;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [5:0] cmd_addr;
    logic [6:0] cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic [5:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic [7:0] ram_q;
    logic       busy, done;
`ifdef PES_RAM_BURST_CHK_EN
    logic [7:0] chk_sum;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] ram_mem [64];
    logic [7:0] ref_mem [64];
    logic [7:0] wdata [64];
    logic [7:0] chk_model;
    int         exp_last_addr;

    pes_ram_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
        .busy(busy), .done(done)
`ifdef PES_RAM_BURST_CHK_EN
        , .chk_sum(chk_sum)
`endif
    );

    always #5 clk = ~clk;

    // RAM: registered read, q holds while we is high.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        else        ram_q <= ram_mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input int addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr[5:0];
        cmd_len   = len[6:0];
        #1;
        check_eq("cmd_ready_at_accept", cmd_ready, 1);
        chk_model = 8'h00;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        #1;
        check_eq({tag, "_idle_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_idle_busy_done"}, {busy, done, ram_we, rd_valid, wr_ready}, 0);
        check_eq({tag, "_idle_ram_addr"}, ram_addr, exp_last_addr);
`ifdef PES_RAM_BURST_CHK_EN
        check_eq({tag, "_idle_chk_sum"}, chk_sum, chk_model);
`endif
        $display("burst %s complete, checks=%0d errors=%0d", tag, n_checks, n_errors);
    endtask

    task automatic write_burst(input int addr, input int len, input int stall_pct);
        int  i = 0;
        int  k = 0;
        int  last = 0;
        bit  seen = 0;
        bit  exp_done;
        send_cmd(1'b1, addr, len);
        while (!seen && k < 400) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            k++;
            wr_valid = (i < len) && ($urandom_range(0, 99) >= stall_pct);
            wr_data  = wr_valid ? wdata[i] : 8'($urandom);
            #1;
            check_eq("wr_ready", wr_ready, (len != 0) && (i < len));
            check_eq("wr_ram_we", ram_we, wr_valid && (i < len));
            if (wr_valid && wr_ready) begin
                check_eq("wr_ram_addr", ram_addr, (addr + i) % 64);
                check_eq("wr_ram_data", ram_data, wdata[i]);
                if (stall_pct == 0) check_eq("wr_beat_cycle", k, i + 1);
                ref_mem[(addr + i) % 64] = wdata[i];
                chk_model ^= wdata[i];
                exp_last_addr = (addr + i) % 64;
                i++;
                last = k;
            end
            exp_done = (i == len) && (k == last + 1);
            check_eq("wr_done", done, exp_done);
            if (exp_done && done) begin
                seen = 1;
                check_eq("wr_done_busy", {busy, cmd_ready}, 2'b10);
`ifdef PES_RAM_BURST_CHK_EN
                check_eq("wr_done_chk_sum", chk_sum, chk_model);
`endif
            end
        end
        wr_valid = 1'b0;
        if (!seen) check_eq("wr_timeout", k, -1);
    endtask

    // mode 0: rd_ready high, 1: random, 2: low for cycles 3..7 after accept
    task automatic read_burst(input int addr, input int len, input int mode);
        int         p = 0;
        int         k = 0;
        int         last = 0;
        bit         seen = 0;
        bit         exp_done;
        bit         prev_stall = 0;
        logic [7:0] prev_data = 0;
        send_cmd(1'b0, addr, len);
        while (!seen && k < 400) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            k++;
            if (mode == 0)      rd_ready = 1'b1;
            else if (mode == 1) rd_ready = 1'($urandom_range(0, 1));
            else                rd_ready = !(k >= 3 && k <= 7);
            #1;
            check_eq("rd_ram_we", ram_we, 0);
            if (prev_stall) begin
                check_eq("rd_hold_valid", rd_valid, 1);
                check_eq("rd_hold_data", rd_data, prev_data);
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (rd_valid && rd_ready) begin
                check_eq("rd_beat_count", p < len, 1);
                check_eq("rd_data", rd_data, ref_mem[(addr + p) % 64]);
                if (mode == 0) check_eq("rd_beat_cycle", k, 3 + p);
                chk_model ^= ref_mem[(addr + p) % 64];
                p++;
                last = k;
            end
            exp_done = (p == len) && (k == last + 1);
            check_eq("rd_done", done, exp_done);
            if (exp_done && done) begin
                seen = 1;
                check_eq("rd_done_busy", {busy, cmd_ready}, 2'b10);
`ifdef PES_RAM_BURST_CHK_EN
                check_eq("rd_done_chk_sum", chk_sum, chk_model);
`endif
            end
        end
        rd_ready = 1'b0;
        if (len > 0) exp_last_addr = (addr + len - 1) % 64;
        if (!seen) check_eq("rd_timeout", k, -1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int l;
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        chk_model = 8'h00; exp_last_addr = 0;
        #12;
        check_eq("reset_cmd_ready", cmd_ready, 1);
        check_eq("reset_flags", {busy, done, rd_valid, wr_ready, ram_we}, 0);
        check_eq("reset_ram_addr_data", {ram_addr, ram_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        write_burst(6'h3E, 4, 0);
        idle_check("wr_3e");
        read_burst(6'h3E, 4, 0);
        idle_check("rd_3e");

        for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom);
        write_burst(6'h3C, 8, 0);
        idle_check("wr_3c");
        read_burst(6'h3C, 8, 2);
        idle_check("rd_stall");

        write_burst(10, 0, 0);
        idle_check("wr_len0");
        read_burst(20, 0, 1);
        idle_check("rd_len0");

        for (int i = 0; i < 64; i++) wdata[i] = 8'($urandom);
        write_burst(5, 64, 0);
        idle_check("wr_wrap64");
        read_burst(5, 64, 1);
        idle_check("rd_wrap64");

        for (int n = 0; n < 15; n++) begin
            a = $urandom_range(0, 63);
            l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
            for (int i = 0; i < 64; i++) wdata[i] = 8'($urandom);
            write_burst(a, l, 30);
            idle_check("wr_rand");
            read_burst($urandom_range(0, 63), $urandom_range(0, 24), 1);
            idle_check("rd_rand");
        end

        // Reset in the middle of a 16-beat write: beat 6 must never land.
        for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
        a = 40;
        send_cmd(1'b1, a, 16);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            wr_valid  = 1'b1;
            wr_data   = wdata[i];
            #1;
            check_eq("rst_pre_ram_we", ram_we, 1);
            ref_mem[(a + i) % 64] = wdata[i];
        end
        @(negedge clk);
        wr_data = wdata[6];
        #1;
        check_eq("rst_pre_beat6_we", ram_we, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_ram_we", ram_we, 0);
        check_eq("rst_async_cmd_ready", cmd_ready, 1);
        check_eq("rst_async_flags", {busy, done, wr_ready}, 0);
        wr_valid = 1'b0;
        exp_last_addr = 0;
        chk_model = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_eq("rst_hold_no_done", {busy, done, ram_we}, 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        read_burst(a, 8, 0);
        idle_check("rd_after_rst");

`ifdef PES_RAM_BURST_CHK_EN
        wdata[0] = 8'h0F; wdata[1] = 8'hF0; wdata[2] = 8'hAA;
        write_burst(20, 3, 0);
        check_eq("chk_sum_wr_55", chk_sum, 8'h55);
        idle_check("chk_wr");
        read_burst(20, 3, 0);
        check_eq("chk_sum_rd_55", chk_sum, 8'h55);
        idle_check("chk_rd");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
